spi_master_param: RTL and testbench

Parametrised SPI master and the successor to the team's fixed 8-bit SPI driver. It adds configurable word width, runtime CPOL/CPHA/bit-order, a programmable SCLK divider, and multiple active-low chip selects. A start/busy/done handshake connects it to a register block or sequencer. It sits between the control logic and the off-chip SPI pins.

---
 rtl/spi_master_param.sv | 204 ++++++++++++++++++++
 tb/tb_spi_master_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// spi_master_param: SPI master with configurable word width, runtime CPOL/CPHA/bit order,
// programmable SCLK divider and decoded active-low chip selects.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; SCLK at latched idle level, all CS high
// ST_LEAD  | CS asserted, SCLK idle for one half period (setup)
// ST_XFER  | SCLK toggling every half period, 2*DATA_W edges
// ST_TRAIL | SCLK idle, CS still asserted for one half period (hold)
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] FIRST_EDGE = EDGE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [EDGE_W-1:0]   edge_num;
  logic                sample_edge;
  logic                advance_edge;
  logic [NUM_CS-1:0]   cs_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      div_q      <= '0;
      edge_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    edge_num = edge_cnt_q + FIRST_EDGE;
    // Odd edges are leading edges; CPHA picks which parity samples MISO.
    sample_edge  = cpha_q ? ~edge_num[0] : edge_num[0];
    // The first bit is already on MOSI at accept, so neither mode shifts before it is sampled.
    advance_edge = cpha_q ? (edge_num[0] && (edge_num != FIRST_EDGE))
                          : (~edge_num[0] && (edge_num != LAST_EDGE));

    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol_q;
        if (start) begin
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsb_d      = lsb_first;
          div_d      = clk_div;
          div_cnt_d  = clk_div;
          edge_cnt_d = '0;
          tx_sh_d    = tx_data;
          rx_sh_d    = '0;
          sclk_d     = cpol;
          mosi_d     = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
          cs_n_d     = cs_dec;
          busy_d     = 1'b1;
          state_d    = ST_LEAD;
        end
      end

      ST_LEAD: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = div_q;
          state_d   = ST_XFER;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      ST_XFER: begin
        if (div_cnt_q == '0) begin
          div_cnt_d  = div_q;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_num;
          if (sample_edge) begin
            rx_sh_d = lsb_q ? {spi_miso, rx_sh_q[DATA_W-1:1]}
                            : {rx_sh_q[DATA_W-2:0], spi_miso};
          end
          if (advance_edge) begin
            tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
            mosi_d  = lsb_q ? tx_sh_q[1] : tx_sh_q[DATA_W-2];
          end
          if (edge_num == LAST_EDGE) state_d = ST_TRAIL;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      ST_TRAIL: begin
        if (div_cnt_q == '0) begin
          cs_n_d    = '1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: an 8-bit/4-CS instance and a 16-bit/1-CS instance
// driven against a mode-aware SPI slave model.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0]  clk_div = 8'd0;
  logic [2:0]  cs_sel = 3'd0;
  logic [31:0] tx_data = 32'd0;
  logic        spi_miso = 1'b0;

  logic [7:0]  rx_a;
  logic        busy_a, done_a, sclk_a, mosi_a;
  logic [3:0]  cs_n_a;
  logic [15:0] rx_b;
  logic        busy_b, done_b, sclk_b, mosi_b;
  logic [0:0]  cs_n_b;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .cs_sel(cs_sel[1:0]),
    .tx_data(tx_data[7:0]), .spi_miso(spi_miso), .rx_data(rx_a),
    .busy(busy_a), .done(done_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a),
    .spi_cs_n(cs_n_a)
  );

  spi_master_param #(.DATA_W(16), .NUM_CS(1), .DIV_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .cs_sel(cs_sel[0:0]),
    .tx_data(tx_data[15:0]), .spi_miso(spi_miso), .rx_data(rx_b),
    .busy(busy_b), .done(done_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b),
    .spi_cs_n(cs_n_b)
  );

  logic        sel_b = 1'b0;
  logic        m_busy, m_done, m_sclk, m_mosi;
  logic [31:0] m_rx;
  logic [3:0]  m_cs_n;

  assign m_busy = sel_b ? busy_b : busy_a;
  assign m_done = sel_b ? done_b : done_a;
  assign m_sclk = sel_b ? sclk_b : sclk_a;
  assign m_mosi = sel_b ? mosi_b : mosi_a;
  assign m_rx   = sel_b ? 32'(rx_b) : 32'(rx_a);
  assign m_cs_n = sel_b ? {3'b111, cs_n_b} : cs_n_a;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model: follows SCLK edges of the selected instance.
  int          sl_dw = 8, sl_h = 1, sl_edges = 0, sl_cnt = 0, sl_gap_err = 0;
  logic        sl_cpha = 1'b0, sl_lsb = 1'b0;
  logic [31:0] sl_tx = 32'd0, sl_rx = 32'd0;
  logic        prev_sclk = 1'b0, prev_busy = 1'b0;
  logic        cur_pol = 1'b0;

  function automatic logic sl_bit(input int i);
    return sl_lsb ? sl_tx[i] : sl_tx[sl_dw-1-i];
  endfunction

  always @(posedge clk) begin
    #1;
    if (m_busy && !prev_busy) begin
      sl_edges = 0; sl_cnt = 0; sl_rx = 0; sl_gap_err = 0;
      spi_miso = sl_bit(0);
    end else if (m_busy) begin
      sl_cnt++;
      if (m_sclk != prev_sclk) begin
        sl_edges++;
        if (sl_cnt != ((sl_edges == 1) ? 2 * sl_h : sl_h)) sl_gap_err++;
        sl_cnt = 0;
        if (((sl_edges % 2) == 1) != sl_cpha) begin
          sl_rx[sl_lsb ? (sl_edges-1)/2 : sl_dw-1-(sl_edges-1)/2] = m_mosi;
        end else if (!sl_cpha && sl_edges < 2 * sl_dw) begin
          spi_miso = sl_bit(sl_edges / 2);
        end else if (sl_cpha && sl_edges > 1) begin
          spi_miso = sl_bit((sl_edges - 1) / 2);
        end
      end
    end
    prev_sclk = m_sclk;
    prev_busy = m_busy;
  end

  // Called at a sample point (#1 after posedge); returns at the sample after the accept edge.
  task automatic start_xfer(input logic b, input logic pol, input logic pha, input logic lsb,
                            input logic [7:0] div, input logic [2:0] cs,
                            input logic [31:0] tx_w, input logic [31:0] sl_w);
    sel_b = b; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div;
    cs_sel = cs; tx_data = tx_w;
    sl_dw = b ? 16 : 8; sl_cpha = pha; sl_lsb = lsb; sl_h = int'(div) + 1; sl_tx = sl_w;
    cur_pol = pol;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // Runs to the done cycle and checks the whole transfer.
  task automatic run_check(input string tag, input logic [31:0] tx_exp, input logic [31:0] rx_exp,
                           input int busy_exp, input logic [3:0] mask_exp, input int restart_at);
    int nb = 0, ncs = 0, nd = 0;
    logic [3:0] seen = 4'b0;
    while (m_busy && nb < 4000) begin
      nb++;
      if (m_cs_n != 4'hF) ncs++;
      seen |= ~m_cs_n;
      if (m_done) nd++;
      if (nb == restart_at) begin
        cs_sel = 3'd1; tx_data = 32'hFF; clk_div = 8'd0; cpol = ~cpol; cpha = ~cpha;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
    end
    check_val({tag, " busy_cycles"}, nb, busy_exp);
    check_val({tag, " done_while_busy"}, nd, 0);
    check_val({tag, " done_at_end"}, m_done, 1);
    check_val({tag, " rx_data"}, m_rx, rx_exp);
    check_val({tag, " mosi_word"}, sl_rx, tx_exp);
    check_val({tag, " sclk_edges"}, sl_edges, 2 * sl_dw);
    check_val({tag, " half_period_err"}, sl_gap_err, 0);
    check_val({tag, " cs_mask"}, seen, mask_exp);
    check_val({tag, " cs_low_cycles"}, ncs, (mask_exp != 4'b0) ? busy_exp : 0);
    check_val({tag, " sclk_idle"}, m_sclk, cur_pol);
  endtask

  task automatic step_idle(input string tag);
    @(posedge clk); #1;
    check_val({tag, " done_width"}, m_done, 0);
    check_val({tag, " busy_after"}, m_busy, 0);
  endtask

  logic [7:0] prev_tx;
  int         nd_rst;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("rst busy", busy_a, 0);
    check_val("rst done", done_a, 0);
    check_val("rst rx", rx_a, 0);
    check_val("rst sclk", sclk_a, 0);
    check_val("rst mosi", mosi_a, 0);
    check_val("rst cs_n_a", cs_n_a, 4'hF);
    check_val("rst cs_n_b", cs_n_b, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Mode 0, H=1, 0xA5 out, 0x3C back.
    start_xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 32'hA5, 32'h3C);
    check_val("t1 first_mosi", m_mosi, 1);
    run_check("t1", 32'hA5, 32'h3C, 18, 4'b0001, 0);
    step_idle("t1");

    // All four modes, H=4, slave echoes the previous byte.
    prev_tx = 8'hA5;
    for (int m = 0; m < 4; m++) begin
      start_xfer(1'b0, m[1], m[0], 1'b0, 8'd3, 3'd0, 32'h81, 32'(prev_tx));
      check_val("t2 lead_sclk", m_sclk, m[1]);
      run_check("t2", 32'h81, 32'(prev_tx), 72, 4'b0001, 0);
      step_idle("t2");
      prev_tx = 8'h81;
    end

    // 16-bit LSB-first.
    start_xfer(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 3'd0, 32'h0001, 32'h8000);
    check_val("t3 first_mosi", m_mosi, 1);
    run_check("t3", 32'h0001, 32'h8000, 34, 4'b0001, 0);
    step_idle("t3");

    // Out-of-range chip select: full timing, no CS, rx still updates.
    start_xfer(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd1, 32'hBEEF, 32'h1234);
    run_check("cs_oor", 32'hBEEF, 32'h1234, 34, 4'b0000, 0);
    step_idle("cs_oor");

    // Chip-select decode, then a start pulsed mid-transfer with new config.
    start_xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd2, 32'h5A, 32'hC3);
    run_check("t4a", 32'h5A, 32'hC3, 36, 4'b0100, 0);
    step_idle("t4a");
    start_xfer(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd3, 32'h96, 32'h69);
    run_check("t4b", 32'h96, 32'h69, 36, 4'b1000, 10);
    step_idle("t4b");

    // Back-to-back: restart in the done cycle.
    start_xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 32'h11, 32'h22);
    run_check("t5a", 32'h11, 32'h22, 18, 4'b0001, 0);
    start_xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 32'h33, 32'h44);
    check_val("t5 busy_gap", m_busy, 1);
    run_check("t5b", 32'h33, 32'h44, 18, 4'b0001, 0);
    step_idle("t5b");

    // Reset after five SCLK edges.
    start_xfer(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 3'd0, 32'hF0, 32'h0F);
    #1;
    for (int k = 0; k < 400 && sl_edges < 5; k++) begin
      @(posedge clk); #2;
    end
    check_val("t6 edges_before_rst", sl_edges, 5);
    rst = 1'b1;
    #1;
    check_val("t6 cs_n", cs_n_a, 4'hF);
    check_val("t6 busy", busy_a, 0);
    check_val("t6 sclk", sclk_a, 0);
    check_val("t6 rx", rx_a, 0);
    check_val("t6 mosi", mosi_a, 0);
    nd_rst = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_a) nd_rst++;
    end
    check_val("t6 no_done", nd_rst, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    start_xfer(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 32'h3C, 32'hC3);
    run_check("t6 after", 32'h3C, 32'hC3, 18, 4'b0001, 0);
    step_idle("t6 after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
